ex_muldiv: RTL

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv.sv
// -----------------------------------------------------------------------------
// ex_muldiv -- iterative 32x32 unsigned multiply / divide unit for the EX stage.
//
// Multiply is shift-add and produces the full 64-bit product in 32 iterations.
// Divide is restoring with a 33-bit partial remainder, also 32 iterations.
// One iteration runs per clock. Start-to-done latency is 33 cycles.
//
// Optional feature macro: EX_MULDIV_DIV_EN
//   defined   : divide datapath present (Op_i = 1 performs A / B, A % B)
//   undefined : no divide logic; an Op_i = 1 request completes in one cycle
//               with a zero result and never raises Busy_o.
//
// Ports:
//   Clock_i  in   1  clock, rising edge
//   Reset_i  in   1  asynchronous active-high reset
//   Start_i  in   1  operation request, sampled in IDLE or DONE
//   Op_i     in   1  0 = unsigned multiply, 1 = unsigned divide
//   Data1_i  in  32  operand A (multiplicand / dividend)
//   Data2_i  in  32  operand B (multiplier / divisor)
//   Busy_o   out  1  high while iterating (pipeline stall)
//   Done_o   out  1  one-cycle completion pulse
//   Hi_o     out 32  product[63:32] or remainder
//   Lo_o     out 32  product[31:0]  or quotient
// -----------------------------------------------------------------------------
module ex_muldiv (
    input  logic        Clock_i,
    input  logic        Reset_i,
    input  logic        Start_i,
    input  logic        Op_i,
    input  logic [31:0] Data1_i,
    input  logic [31:0] Data2_i,
    output logic        Busy_o,
    output logic        Done_o,
    output logic [31:0] Hi_o,
    output logic [31:0] Lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q,   cnt_d;
    logic [31:0] a_q,     a_d;      // multiplicand
    logic [32:0] hi_w_q,  hi_w_d;   // product high half / partial remainder
    logic [31:0] lo_w_q,  lo_w_d;   // multiplier shifting out / quotient shifting in
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;

`ifdef EX_MULDIV_DIV_EN
    logic        op_q,    op_d;     // 1 = divide in progress
    logic [31:0] b_q,     b_d;      // divisor
`endif

    // ------------------------------------------------------------------
    // Multiply iteration: conditionally add A into the high half, then
    // shift the whole {hi, lo} pair right by one. The add carry lands in
    // the top bit before the shift, so no product bit is lost.
    // ------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [32:0] mul_hi_nx;
    logic [31:0] mul_lo_nx;

    always_comb begin
        mul_sum   = hi_w_q + (lo_w_q[0] ? {1'b0, a_q} : 33'd0);
        mul_hi_nx = {1'b0, mul_sum[32:1]};
        mul_lo_nx = {mul_sum[0], lo_w_q[31:1]};
    end

`ifdef EX_MULDIV_DIV_EN
    // ------------------------------------------------------------------
    // Restoring divide iteration: shift the next dividend bit into the
    // remainder, trial-subtract the divisor, keep the difference when it
    // is non-negative. A zero divisor always "fits", which naturally gives
    // an all-ones quotient and a remainder equal to the dividend.
    // ------------------------------------------------------------------
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic        div_fit;
    logic [32:0] div_hi_nx;
    logic [31:0] div_lo_nx;

    always_comb begin
        div_shift = {hi_w_q[31:0], lo_w_q[31]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_q};
        div_fit   = ~div_diff[33];
        div_hi_nx = div_fit ? div_diff[32:0] : div_shift;
        div_lo_nx = {lo_w_q[30:0], div_fit};
    end
`endif

    // Iteration result selected by the latched operation.
    logic [32:0] iter_hi;
    logic [31:0] iter_lo;

    always_comb begin
        iter_hi = mul_hi_nx;
        iter_lo = mul_lo_nx;
`ifdef EX_MULDIV_DIV_EN
        if (op_q) begin
            iter_hi = div_hi_nx;
            iter_lo = div_lo_nx;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        hi_w_d  = hi_w_q;
        lo_w_d  = lo_w_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef EX_MULDIV_DIV_EN
        op_d    = op_q;
        b_d     = b_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (Start_i) begin
                    cnt_d  = 6'd0;
                    hi_w_d = 33'd0;
`ifdef EX_MULDIV_DIV_EN
                    a_d     = Data1_i;
                    b_d     = Data2_i;
                    op_d    = Op_i;
                    // Multiply shifts B out of lo; divide shifts A out of lo.
                    lo_w_d  = Op_i ? Data1_i : Data2_i;
                    state_d = S_BUSY;
`else
                    if (Op_i) begin
                        // No divider: complete immediately with a zero result.
                        hi_d    = 32'd0;
                        lo_d    = 32'd0;
                        state_d = S_DONE;
                    end else begin
                        a_d     = Data1_i;
                        lo_w_d  = Data2_i;
                        state_d = S_BUSY;
                    end
`endif
                end
            end

            S_BUSY: begin
                hi_w_d = iter_hi;
                lo_w_d = iter_lo;
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    // 32nd iteration: publish the finished result only.
                    hi_d    = iter_hi[31:0];
                    lo_d    = iter_lo;
                    state_d = S_DONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            a_q     <= 32'd0;
            hi_w_q  <= 33'd0;
            lo_w_q  <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
`ifdef EX_MULDIV_DIV_EN
            op_q    <= 1'b0;
            b_q     <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            hi_w_q  <= hi_w_d;
            lo_w_q  <= lo_w_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef EX_MULDIV_DIV_EN
            op_q    <= op_d;
            b_q     <= b_d;
`endif
        end
    end

    assign Busy_o = (state_q == S_BUSY);
    assign Done_o = (state_q == S_DONE);
    assign Hi_o   = hi_q;
    assign Lo_o   = lo_q;

endmodule
